// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and derived raster bounds.
package vga_timing_pkg;
    localparam int CW = 10;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BACK_DEF = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BACK_DEF = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF = 10;
    localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;
    localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;
    localparam int H_ACT_START = H_SYNC_DEF + H_BACK_DEF;
    localparam int H_ACT_END = H_TOTAL - H_FRONT_DEF;
    localparam int V_ACT_START = V_SYNC_DEF + V_BACK_DEF;
    localparam int V_ACT_END = V_TOTAL - V_FRONT_DEF;
    typedef logic [CW-1:0] coord_t;
endpackage

// File: rtl/VGAcomparator.sv
// VGAcomparator: unsigned less-than used for sync pulse decode.
module VGAcomparator
    import vga_timing_pkg::*;
#(
    parameter int W = CW
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o
);
    assign lt_o = a_i < b_i;
endmodule

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter 0..MAX advancing on inc, wrap flags the rollover.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int W = CW,
    parameter int MAX = H_TOTAL - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);
    logic [W-1:0] count_q, count_d;
    always_comb begin
        wrap = inc && count_q == W'(MAX);
        count_d = wrap ? '0 : inc ? count_q + 1'b1 : count_q;
        count = count_q;
    end
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: pixel divider, h/v raster counters, sync and active-video decode.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BACK = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BACK = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT = V_FRONT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pix_en,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);
    localparam int HT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HA0 = H_SYNC + H_BACK;
    localparam int HA1 = HT - H_FRONT;
    localparam int VA0 = V_SYNC + V_BACK;
    localparam int VA1 = VT - V_FRONT;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    if (HT > (1 << CW) || VT > (1 << CW) || CLK_DIV < 1) begin : g_bad_timing
        $error("vga_timing_controller: totals exceed counter range or CLK_DIV < 1");
    end

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h, v;
    logic h_wrap, unused_v_wrap, h_lt, v_lt;

    // pix_en is masked during reset so no pixel is credited on the reset cycle
    always_comb begin
        pix_en = enable && !reset && div_q == DW'(CLK_DIV - 1);
        div_d = !enable ? div_q : pix_en ? '0 : div_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) div_q <= '0;
        else div_q <= div_d;
    end

    vga_axis_counter #(.W(CW), .MAX(HT - 1)) u_h_cnt (
        .clk(clk), .reset(reset), .inc(pix_en), .count(h), .wrap(h_wrap)
    );
    vga_axis_counter #(.W(CW), .MAX(VT - 1)) u_v_cnt (
        .clk(clk), .reset(reset), .inc(h_wrap), .count(v), .wrap(unused_v_wrap)
    );

    VGAcomparator #(.W(CW)) u_h_cmp (.a_i(h), .b_i(CW'(H_SYNC)), .lt_o(h_lt));
    VGAcomparator #(.W(CW)) u_v_cmp (.a_i(v), .b_i(CW'(V_SYNC)), .lt_o(v_lt));

    always_comb begin
        hsync_n = ~h_lt;
        vsync_n = ~v_lt;
        active = h >= CW'(HA0) && h < CW'(HA1) && v >= CW'(VA0) && v < CW'(VA1);
        x = active ? h - CW'(HA0) : '0;
        y = active ? v - CW'(VA0) : '0;
        line_start = pix_en && h == '0;
        frame_start = line_start && v == '0;
    end
endmodule
